// File: rtl/oled_cmd_arbiter_pkg.sv
// oled_cmd_arbiter_pkg
//    Command codes and FSM state encoding shared by the OLED command
//    arbiter, its selector and the command requesters.
//    No ports; provides CMD_* constants, arb_state_e and idx2oh().
package oled_cmd_arbiter_pkg;

   localparam logic [3:0] CMD_INIT_REGS = 4'h1;
   localparam logic [3:0] CMD_CLS_GRAM  = 4'h2;
   localparam logic [3:0] CMD_WR_GRAM   = 4'h3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RELEASE = 2'd3
   } arb_state_e;

   // Requester index -> one-hot ack/err vector.
   function automatic logic [2:0] idx2oh(input logic [1:0] idx);
      logic [2:0] oh;
      oh = 3'b000;
      case (idx)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/oled_rr_pick.sv
// oled_rr_pick
//    Combinational winner select: requester 0 has fixed top priority,
//    requesters 1 and 2 share the remaining slot round-robin.
//    req_i  : level requests
//    mask_i : per-requester eligibility (1 = may be granted)
//    rr_i   : 0 = prefer requester 1, 1 = prefer requester 2
//    vld_o  : some eligible request is pending
//    idx_o  : winner index (0..2), 0 when vld_o is low
module oled_rr_pick
   import oled_cmd_arbiter_pkg::*;
(
   input  logic [2:0] req_i,
   input  logic [2:0] mask_i,
   input  logic       rr_i,
   output logic       vld_o,
   output logic [1:0] idx_o
);

   logic [2:0] elig;

   always_comb begin
      elig  = req_i & mask_i;
      vld_o = |elig;
      idx_o = 2'd0;
      if (elig[0])                 idx_o = 2'd0;
      else if (elig[1] && elig[2]) idx_o = rr_i ? 2'd2 : 2'd1;
      else if (elig[1])            idx_o = 2'd1;
      else if (elig[2])            idx_o = 2'd2;
   end

endmodule

// File: rtl/oled_cmd_arbiter.sv
// oled_cmd_arbiter
//    Arbitrates three command requesters onto a single OLED engine port.
//    clk, rst_n              : clock, async active-low reset
//    req_i[2:0]              : level requests (0 = system/init requester)
//    cmdN_i/addrN_i/xN_i/yN_i: command fields of requester N
//    ack_o/err_o[2:0]        : one-cycle done / timeout pulse to winner
//    eng_en_o, eng_*_o       : engine command port, held for a transaction
//    eng_done_i              : engine completion, looked at only in WAIT
//    busy_o                  : FSM not in IDLE
//    init_ok_o               : sticky, set by a completed CMD_INIT_REGS
module oled_cmd_arbiter
   import oled_cmd_arbiter_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req_i,
   input  logic [3:0] cmd0_i,
   input  logic [3:0] cmd1_i,
   input  logic [3:0] cmd2_i,
   input  logic [3:0] addr0_i,
   input  logic [3:0] addr1_i,
   input  logic [3:0] addr2_i,
   input  logic [7:0] x0_i,
   input  logic [7:0] x1_i,
   input  logic [7:0] x2_i,
   input  logic [2:0] y0_i,
   input  logic [2:0] y1_i,
   input  logic [2:0] y2_i,
   output logic [2:0] ack_o,
   output logic [2:0] err_o,
   output logic       eng_en_o,
   output logic [3:0] eng_cmd_o,
   output logic [3:0] eng_addr_o,
   output logic [7:0] eng_x_o,
   output logic [2:0] eng_y_o,
   input  logic       eng_done_i,
   output logic       busy_o,
   output logic       init_ok_o
);

   localparam logic [23:0] TMO_LAST = TIMEOUT_CYCLES - 24'd1;

   arb_state_e  state_q;
   logic [1:0]  win_q;
   logic        rr_q;
   logic        init_ok_q;
   logic        eng_en_q;
   logic [3:0]  eng_cmd_q, eng_addr_q;
   logic [7:0]  eng_x_q;
   logic [2:0]  eng_y_q;
   logic [2:0]  ack_q, err_q;
   logic [23:0] cnt_q, cnt_d;

   logic        pick_vld;
   logic [1:0]  pick_idx;
   logic [3:0]  sel_cmd, sel_addr;
   logic [7:0]  sel_x;
   logic [2:0]  sel_y;

   // Until the panel registers are initialised only requester 0 may talk.
   oled_rr_pick u_pick (
      .req_i  (req_i),
      .mask_i ({init_ok_q, init_ok_q, 1'b1}),
      .rr_i   (rr_q),
      .vld_o  (pick_vld),
      .idx_o  (pick_idx)
   );

   always_comb begin
      sel_cmd  = cmd0_i;
      sel_addr = addr0_i;
      sel_x    = x0_i;
      sel_y    = y0_i;
      case (pick_idx)
         2'd1: begin
            sel_cmd = cmd1_i; sel_addr = addr1_i; sel_x = x1_i; sel_y = y1_i;
         end
         2'd2: begin
            sel_cmd = cmd2_i; sel_addr = addr2_i; sel_x = x2_i; sel_y = y2_i;
         end
         default: ;
      endcase
   end

   // Saturating so a mis-set timeout can never wrap back to zero.
   assign cnt_d = (cnt_q == 24'hFF_FFFF) ? cnt_q : cnt_q + 24'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         win_q      <= 2'd0;
         rr_q       <= 1'b0;
         init_ok_q  <= 1'b0;
         eng_en_q   <= 1'b0;
         eng_cmd_q  <= 4'd0;
         eng_addr_q <= 4'd0;
         eng_x_q    <= 8'd0;
         eng_y_q    <= 3'd0;
         ack_q      <= 3'b000;
         err_q      <= 3'b000;
         cnt_q      <= 24'd0;
      end else begin
         ack_q <= 3'b000;
         err_q <= 3'b000;
         case (state_q)
            S_IDLE: begin
               if (pick_vld) begin
                  win_q      <= pick_idx;
                  eng_cmd_q  <= sel_cmd;
                  eng_addr_q <= sel_addr;
                  eng_x_q    <= sel_x;
                  eng_y_q    <= sel_y;
                  // Point rr at the other shared requester; grant 0 leaves it.
                  if (pick_idx == 2'd1)      rr_q <= 1'b1;
                  else if (pick_idx == 2'd2) rr_q <= 1'b0;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               eng_en_q <= 1'b1;
               cnt_q    <= 24'd0;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               // done is tested first so it wins over a coincident timeout
               if (eng_done_i) begin
                  eng_en_q <= 1'b0;
                  ack_q    <= idx2oh(win_q);
                  if (win_q == 2'd0 && eng_cmd_q == CMD_INIT_REGS)
                     init_ok_q <= 1'b1;
                  state_q  <= S_RELEASE;
               end else if (cnt_q == TMO_LAST) begin
                  eng_en_q <= 1'b0;
                  err_q    <= idx2oh(win_q);
                  state_q  <= S_RELEASE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_RELEASE: state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   assign ack_o      = ack_q;
   assign err_o      = err_q;
   assign eng_en_o   = eng_en_q;
   assign eng_cmd_o  = eng_cmd_q;
   assign eng_addr_o = eng_addr_q;
   assign eng_x_o    = eng_x_q;
   assign eng_y_o    = eng_y_q;
   assign busy_o     = (state_q != S_IDLE);
   assign init_ok_o  = init_ok_q;

endmodule

// File: tb/tb_oled_cmd_arbiter.sv
// tb_oled_cmd_arbiter
//    Directed bench: boot/init gating, a table of arbitration vectors,
//    then hand-written timeout, coincidence, field-hold and reset cases.
module tb_oled_cmd_arbiter;
   import oled_cmd_arbiter_pkg::*;

   logic       clk, rst_n;
   logic [2:0] req;
   logic [3:0] cmd0, cmd1, cmd2, addr0, addr1, addr2;
   logic [7:0] x0, x1, x2;
   logic [2:0] y0, y1, y2;
   logic [2:0] ack, err;
   logic       eng_en, eng_done, busy, init_ok;
   logic [3:0] eng_cmd, eng_addr;
   logic [7:0] eng_x;
   logic [2:0] eng_y;

   oled_cmd_arbiter #(.TIMEOUT_CYCLES(24'd100)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req),
      .cmd0_i(cmd0), .cmd1_i(cmd1), .cmd2_i(cmd2),
      .addr0_i(addr0), .addr1_i(addr1), .addr2_i(addr2),
      .x0_i(x0), .x1_i(x1), .x2_i(x2),
      .y0_i(y0), .y1_i(y1), .y2_i(y2),
      .ack_o(ack), .err_o(err),
      .eng_en_o(eng_en), .eng_cmd_o(eng_cmd), .eng_addr_o(eng_addr),
      .eng_x_o(eng_x), .eng_y_o(eng_y), .eng_done_i(eng_done),
      .busy_o(busy), .init_ok_o(init_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   typedef struct {
      logic [2:0] rq;
      int         dly;
      int         w;
   } vec_t;

   vec_t       tbl [11];
   logic [3:0] exp_addr [3];

   // One transaction: raise rq, expect winner w, done after dly WAIT cycles.
   task automatic txn(input logic [2:0] rq, input int dly, input int w, input string nm);
      int n;
      @(posedge clk); #1 req = rq;
      n = 0;
      do begin @(negedge clk); n++; end while (!eng_en && n < 20);
      chk({nm, " grant"}, 32'({eng_en, eng_addr}), 32'({1'b1, exp_addr[w]}));
      if (!eng_en) begin
         req = 3'b000;
         return;
      end
      repeat (dly - 1) @(negedge clk);
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
      chk({nm, " ack"}, 32'(ack), 32'(3'(3'b001 << w)));
      chk({nm, " err"}, 32'(err), 32'd0);
      @(posedge clk); #1 req = 3'b000;
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, hi, bad, seen;
      rst_n = 1'b0; req = 3'b000; eng_done = 1'b0;
      cmd0 = CMD_INIT_REGS; addr0 = 4'd1; x0 = 8'd10;  y0 = 3'd1;
      cmd1 = CMD_CLS_GRAM;  addr1 = 4'd5; x1 = 8'd64;  y1 = 3'd5;
      cmd2 = CMD_WR_GRAM;   addr2 = 4'd9; x2 = 8'd112; y2 = 3'd2;
      exp_addr[0] = 4'd1; exp_addr[1] = 4'd5; exp_addr[2] = 4'd9;

      tbl[0]  = '{3'b111, 2, 0};
      tbl[1]  = '{3'b111, 1, 0};
      tbl[2]  = '{3'b110, 1, 2};
      tbl[3]  = '{3'b110, 3, 1};
      tbl[4]  = '{3'b110, 1, 2};
      tbl[5]  = '{3'b100, 1, 2};
      tbl[6]  = '{3'b110, 2, 1};
      tbl[7]  = '{3'b011, 1, 0};
      tbl[8]  = '{3'b110, 1, 2};
      tbl[9]  = '{3'b010, 1, 1};
      tbl[10] = '{3'b100, 1, 2};

      repeat (3) @(negedge clk);
      chk("reset ctl", 32'({eng_en, busy, init_ok, ack, err}), 32'd0);
      chk("reset fields", 32'({eng_cmd, eng_addr, eng_x, eng_y}), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Boot: 1 and 2 are masked until init completes.
      req = 3'b110;
      seen = 0;
      repeat (10) begin @(negedge clk); if (busy || eng_en) seen++; end
      chk("boot masked", 32'(seen), 32'd0);
      chk("boot init_ok pre", 32'(init_ok), 32'd0);
      txn(3'b111, 50, 0, "boot init");
      chk("boot init_ok", 32'(init_ok), 32'd1);
      txn(3'b110, 5, 1, "boot r1");
      cmd0 = CMD_CLS_GRAM;

      for (int i = 0; i < 11; i++)
         txn(tbl[i].rq, tbl[i].dly, tbl[i].w, $sformatf("vec%0d", i));

      // Timeout on requester 1: 100 WAIT cycles, err only, then IDLE.
      @(posedge clk); #1 req = 3'b010;
      n = 0;
      do begin @(negedge clk); n++; end while (!eng_en && n < 20);
      chk("to grant", 32'({eng_en, eng_addr}), 32'({1'b1, 4'd5}));
      hi = 0;
      while (eng_en && hi < 200) begin hi++; @(negedge clk); end
      chk("to wait cycles", 32'(hi), 32'd100);
      chk("to err", 32'(err), 32'(3'b010));
      chk("to no ack", 32'(ack), 32'd0);
      @(posedge clk); #1 req = 3'b000;
      @(negedge clk);
      chk("to idle", 32'(busy), 32'd0);

      // Done lands on the same cycle as the timeout (count 99).
      txn(3'b010, 100, 1, "coincide");

      // Requester 2 fields held from ISSUE through WAIT.
      @(posedge clk); #1 req = 3'b100;
      n = 0;
      do begin @(negedge clk); n++; end while (!busy && n < 20);
      chk("fld x", 32'(eng_x), 32'd112);
      chk("fld cmd/addr/y", 32'({eng_cmd, eng_addr, eng_y}), 32'({CMD_WR_GRAM, 4'd9, 3'd2}));
      bad = 0;
      @(negedge clk);
      for (int k = 1; k <= 10; k++) begin
         if (!eng_en || {eng_cmd, eng_addr, eng_x, eng_y} != {CMD_WR_GRAM, 4'd9, 8'd112, 3'd2})
            bad++;
         if (k == 10) eng_done = 1'b1;
         @(negedge clk);
      end
      eng_done = 1'b0;
      chk("fld stable", 32'(bad), 32'd0);
      chk("fld ack", 32'(ack), 32'(3'b100));
      @(posedge clk); #1 req = 3'b000;
      @(negedge clk);

      // Reset in the middle of WAIT.
      @(posedge clk); #1 req = 3'b001;
      n = 0;
      do begin @(negedge clk); n++; end while (!eng_en && n < 20);
      chk("rst pre en", 32'(eng_en), 32'd1);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst async", 32'({eng_en, busy, init_ok, ack, err}), 32'd0);
      chk("rst fields", 32'({eng_cmd, eng_addr, eng_x, eng_y}), 32'd0);
      seen = 0;
      repeat (3) begin @(negedge clk); if (ack != 3'b000 || err != 3'b000) seen++; end
      req = 3'b010;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (ack != 3'b000 || err != 3'b000) seen++;
      end
      chk("rst no pulse", 32'(seen), 32'd0);
      chk("rst masked", 32'({busy, init_ok}), 32'd0);
      req = 3'b000;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
